// File: rtl/dcache_controller.sv
// Direct-mapped write-back write-allocate L1 data cache.
// Hits complete in the access cycle; misses stall for writeback + fill.
module dcache_controller #(
  parameter int LINES = 32,
  parameter int TAG_W = 22
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [31:0]  p1_addr_i,
  input  logic [31:0]  p1_data_i,
  input  logic         p1_MemRead_i,
  input  logic         p1_MemWrite_i,
  output logic [31:0]  p1_data_o,
  output logic         p1_stall_o,
  output logic [31:0]  mem_addr_o,
  output logic [255:0] mem_data_o,
  output logic         mem_enable_o,
  output logic         mem_write_o,
  input  logic [255:0] mem_data_i,
  input  logic         mem_ack_i
);
  localparam int IDX_W = $clog2(LINES);

  typedef enum logic [1:0] {
    IDLE,
    WRITEBACK,
    ALLOCATE,
    FILL
  } state_t;

  state_t state_q, state_d;

  logic [LINES-1:0] valid_q;
  logic [LINES-1:0] dirty_q;
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [255:0]     line_q [LINES];

  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic [2:0]       wsel;
  logic             req;
  logic             hit;
  logic             store_en;
  logic             fill_en;
  logic             unused_addr;

  assign idx  = p1_addr_i[5 +: IDX_W];
  assign tag  = p1_addr_i[31 -: TAG_W];
  assign wsel = p1_addr_i[4:2];
  assign unused_addr = ^p1_addr_i[1:0];

  assign req = p1_MemRead_i | p1_MemWrite_i;
  assign hit = req & valid_q[idx] & (tag_q[idx] == tag);

  assign p1_stall_o = req & ~hit;
  assign p1_data_o  = hit ? line_q[idx][wsel*32 +: 32] : '0;
  assign store_en   = (state_q == IDLE) & hit & p1_MemWrite_i;

  always_comb begin
    state_d      = state_q;
    mem_enable_o = 1'b0;
    mem_write_o  = 1'b0;
    mem_addr_o   = '0;
    mem_data_o   = '0;
    fill_en      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req && !hit) begin
          if (valid_q[idx] && dirty_q[idx]) state_d = WRITEBACK;
          else                              state_d = ALLOCATE;
        end
      end
      WRITEBACK: begin
        mem_enable_o = 1'b1;
        mem_write_o  = 1'b1;
        mem_addr_o   = {tag_q[idx], idx, 5'b0};
        mem_data_o   = line_q[idx];
        if (mem_ack_i) state_d = ALLOCATE;
      end
      ALLOCATE: begin
        mem_enable_o = 1'b1;
        mem_addr_o   = {tag, idx, 5'b0};
        if (mem_ack_i) state_d = FILL;
      end
      FILL: begin
        // read data arrives the cycle after ack
        fill_en = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      state_q <= state_d;
      if (fill_en) begin
        valid_q[idx] <= 1'b1;
        dirty_q[idx] <= 1'b0;
      end else if (store_en) begin
        dirty_q[idx] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (fill_en) begin
      tag_q[idx]  <= tag;
      line_q[idx] <= mem_data_i;
    end else if (store_en) begin
      line_q[idx][wsel*32 +: 32] <= p1_data_i;
    end
  end
endmodule

// File: tb/tb_dcache_controller.sv
// Randomized bench for dcache_controller with a line-level cache model
// and a fixed-latency memory responder.
module tb_dcache_controller;
  logic         clk;
  logic         rst_i;
  logic [31:0]  p1_addr;
  logic [31:0]  p1_wdata;
  logic         p1_rd;
  logic         p1_wr;
  logic [31:0]  p1_data_o;
  logic         p1_stall_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o;
  logic         mem_enable_o;
  logic         mem_write_o;
  logic [255:0] mem_data_i;
  logic         mem_ack_i;

  dcache_controller dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .p1_addr_i    (p1_addr),
    .p1_data_i    (p1_wdata),
    .p1_MemRead_i (p1_rd),
    .p1_MemWrite_i(p1_wr),
    .p1_data_o    (p1_data_o),
    .p1_stall_o   (p1_stall_o),
    .mem_addr_o   (mem_addr_o),
    .mem_data_o   (mem_data_o),
    .mem_enable_o (mem_enable_o),
    .mem_write_o  (mem_write_o),
    .mem_data_i   (mem_data_i),
    .mem_ack_i    (mem_ack_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         wr;
    logic [31:0]  a;
    logic [255:0] d;
  } txn_t;

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [255:0] act,
                       input logic [255:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  function automatic logic [255:0] init_line(input logic [31:0] a);
    logic [255:0] l;
    for (int w = 0; w < 8; w++) begin
      if (a == 32'h400) l[w*32 +: 32] = 32'h1111_1111 * (w + 1);
      else l[w*32 +: 32] = a ^ (w * 32'h9E37_79B9) ^ 32'h5A5A_0000;
    end
    return l;
  endfunction

  // memory responder: ack on the 10th cycle after accepting enable
  logic [255:0] mem [logic [31:0]];
  txn_t         log_q[$];
  int           cnt;
  logic         lat_wr;
  logic [31:0]  lat_a;
  logic [255:0] lat_d;
  logic         fill_vld;
  logic [255:0] fill_line;
  logic [255:0] junk;

  function automatic logic [255:0] mem_line(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return init_line(a);
  endfunction

  assign mem_ack_i  = (cnt == 10);
  assign mem_data_i = fill_vld ? fill_line : junk;

  always @(posedge clk) begin
    junk <= {$urandom, $urandom, $urandom, $urandom,
             $urandom, $urandom, $urandom, $urandom};
    fill_vld <= 1'b0;
    if (!rst_i) begin
      cnt <= 0;
    end else if (cnt == 10) begin
      cnt <= 0;
      log_q.push_back('{wr: lat_wr, a: lat_a, d: lat_d});
      if (lat_wr) mem[lat_a] = lat_d;
      else begin
        fill_vld  <= 1'b1;
        fill_line <= mem_line(lat_a);
      end
    end else if (mem_enable_o) begin
      if (cnt == 0) begin
        lat_wr <= mem_write_o;
        lat_a  <= mem_addr_o;
        lat_d  <= mem_data_o;
      end
      cnt <= cnt + 1;
    end
  end

  // reference model: cache contents and memory image
  logic [255:0] ref_mem [logic [31:0]];
  logic [31:0]  mv;
  logic [31:0]  mdirty;
  logic [21:0]  mt [32];
  logic [255:0] mline [32];

  function automatic logic [255:0] ref_line(input logic [31:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return init_line(a);
  endfunction

  logic        chk_en = 1'b0;
  logic        exp_stall;
  logic [31:0] exp_data;
  logic        exp_en;
  logic        exp_wr;

  always @(negedge clk) begin
    if (chk_en) begin
      check("stall", p1_stall_o, exp_stall);
      check("rdata", p1_data_o, exp_data);
      check("mem_enable", mem_enable_o, exp_en);
      check("mem_write", mem_write_o, exp_wr);
      check("addr_low", mem_addr_o[4:0], 5'd0);
      if (cnt > 0) begin
        check("hold_en", mem_enable_o, 1'b1);
        check("hold_wr", mem_write_o, lat_wr);
        check("hold_addr", mem_addr_o, lat_a);
        if (lat_wr) check("hold_data", mem_data_o, lat_d);
      end
    end
  end

  txn_t        exp_q[$];
  int          nstall;
  logic [31:0] dut_word;

  task automatic set_idle();
    p1_rd     = 1'b0;
    p1_wr     = 1'b0;
    exp_stall = 1'b0;
    exp_data  = '0;
    exp_en    = 1'b0;
    exp_wr    = 1'b0;
  endtask

  task automatic access(input logic [31:0] a, input logic [31:0] wd,
                        input logic rd, input logic wr, input int rst_k);
    logic [4:0]  idx;
    logic [21:0] tg;
    logic [2:0]  ws;
    logic [31:0] la;
    logic [31:0] word;
    logic        dirty_miss;
    int          ncyc;
    idx = a[9:5];
    tg  = a[31:10];
    ws  = a[4:2];
    la  = {a[31:5], 5'b0};
    dirty_miss = 1'b0;
    exp_q.delete();
    log_q.delete();
    if (mv[idx] && mt[idx] == tg) begin
      ncyc = 0;
    end else begin
      ncyc = 13;
      if (mv[idx] && mdirty[idx]) begin
        ncyc = 24;
        dirty_miss = 1'b1;
        exp_q.push_back('{wr: 1'b1, a: {mt[idx], idx, 5'b0}, d: mline[idx]});
        ref_mem[{mt[idx], idx, 5'b0}] = mline[idx];
      end
      exp_q.push_back('{wr: 1'b0, a: la, d: '0});
      mline[idx]  = ref_line(la);
      mv[idx]     = 1'b1;
      mdirty[idx] = 1'b0;
      mt[idx]     = tg;
    end
    word     = mline[idx][ws*32 +: 32];
    p1_addr  = a;
    p1_wdata = wd;
    p1_rd    = rd;
    p1_wr    = wr;
    nstall   = 0;
    for (int k = 0; k <= ncyc + 1; k++) begin
      exp_stall = (k < ncyc);
      exp_data  = (k < ncyc) ? 32'd0 : word;
      exp_en    = (k > 0) && (k < ncyc - 1);
      exp_wr    = dirty_miss && (k >= 1) && (k <= 11);
      if (rst_k > 0 && k == rst_k + 1) begin
        exp_stall = 1'b1;
        exp_data  = '0;
        exp_en    = 1'b0;
        exp_wr    = 1'b0;
      end
      @(negedge clk);
      if (p1_stall_o) nstall++;
      if (rst_k > 0 && k == rst_k + 1) begin
        check("rst_addr", mem_addr_o, 32'd0);
        check("rst_data", mem_data_o, 256'd0);
        @(posedge clk);
        #1;
        rst_i = 1'b1;
        set_idle();
        mv     = '0;
        mdirty = '0;
        check("rst_no_txn", log_q.size(), 0);
        return;
      end
      if (rst_k > 0 && k == rst_k) rst_i = 1'b0;
      if (k == ncyc) begin
        dut_word = p1_data_o;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (wr) begin
      mline[idx][ws*32 +: 32] = wd;
      mdirty[idx] = 1'b1;
    end
    @(posedge clk);
    #1;
    set_idle();
    check("txn_count", log_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
      check("txn_wr", log_q[i].wr, exp_q[i].wr);
      check("txn_addr", log_q[i].a, exp_q[i].a);
      if (exp_q[i].wr) check("txn_data", log_q[i].d, exp_q[i].d);
    end
  endtask

  logic [255:0] tmp_line;
  logic [4:0]   idx_tab [4];

  initial begin
    idx_tab[0] = 5'd0;
    idx_tab[1] = 5'd1;
    idx_tab[2] = 5'd2;
    idx_tab[3] = 5'd31;
    mv       = '0;
    mdirty   = '0;
    p1_addr  = '0;
    p1_wdata = '0;
    rst_i    = 1'b0;
    set_idle();
    repeat (3) @(posedge clk);
    #1;
    chk_en = 1'b1;
    @(negedge clk);
    rst_i = 1'b1;
    @(posedge clk);
    #1;

    access(32'h400, 32'd0, 1'b1, 1'b0, 0);
    check("clean_miss_stall", nstall, 13);
    check("fill_addr_400", log_q.size() > 0 ? log_q[0].a : 32'hFFFF_FFFF, 32'h400);
    check("fill_is_read", log_q.size() > 0 ? log_q[0].wr : 1'b1, 1'b0);
    check("fill_word0", dut_word, 32'h1111_1111);

    access(32'h404, 32'hDEAD_BEEF, 1'b0, 1'b1, 0);
    check("store_hit_stall", nstall, 0);
    access(32'h404, 32'd0, 1'b1, 1'b0, 0);
    check("load_after_store", dut_word, 32'hDEAD_BEEF);

    access(32'h804, 32'd0, 1'b1, 1'b0, 0);
    check("dirty_miss_stall", nstall, 24);
    check("wb_addr", log_q.size() > 1 ? log_q[0].a : 32'hFFFF_FFFF, 32'h400);
    tmp_line = log_q.size() > 1 ? log_q[0].d : '0;
    check("wb_word1", tmp_line[63:32], 32'hDEAD_BEEF);
    check("fill_addr_800", log_q.size() > 1 ? log_q[1].a : 32'hFFFF_FFFF, 32'h800);
    tmp_line = init_line(32'h800);
    check("new_line_word", dut_word, tmp_line[63:32]);

    access(32'hC08, 32'h1234_5678, 1'b0, 1'b1, 0);
    check("store_miss_stall", nstall, 13);
    access(32'hC08, 32'd0, 1'b1, 1'b0, 0);
    check("store_miss_word", dut_word, 32'h1234_5678);
    access(32'hC04, 32'd0, 1'b1, 1'b0, 0);
    tmp_line = init_line(32'hC00);
    check("store_miss_other", dut_word, tmp_line[63:32]);

    access(32'h404, 32'd0, 1'b1, 1'b0, 0);
    check("reload_dirty_stall", nstall, 24);
    check("wb_addr_c00", log_q.size() > 1 ? log_q[0].a : 32'hFFFF_FFFF, 32'hC00);
    tmp_line = log_q.size() > 1 ? log_q[0].d : '0;
    check("wb_word2", tmp_line[95:64], 32'h1234_5678);
    check("reload_word", dut_word, 32'hDEAD_BEEF);

    access(32'h1020, 32'd0, 1'b1, 1'b0, 5);
    access(32'h404, 32'd0, 1'b1, 1'b0, 0);
    check("post_reset_miss", nstall, 13);

    access(32'h404, 32'hCAFE_F00D, 1'b1, 1'b1, 0);
    check("both_hit_stall", nstall, 0);
    access(32'h404, 32'd0, 1'b1, 1'b0, 0);
    check("both_is_store", dut_word, 32'hCAFE_F00D);

    for (int n = 0; n < 200; n++) begin
      logic [31:0] ra;
      logic        rrd;
      logic        rwr;
      ra  = {22'($urandom_range(1, 5)), idx_tab[$urandom_range(0, 3)],
             3'($urandom_range(0, 7)), 2'b00};
      rrd = 1'($urandom);
      rwr = 1'($urandom);
      if (!rrd && !rwr) rrd = 1'b1;
      access(ra, $urandom, rrd, rwr, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
